frame_decimator: RTL and testbench
==================================

# frame_decimator

Upstream capture stage for the 128×128 on-chip image buffer. On a start request it waits for the next camera frame and keeps every third pixel of a centred 384×384 window of the 640×480 RGB stream. It truncates each 12-bit channel to 8 bits and issues exactly 16384 sequential 24-bit write strobes to the image buffer controller. Because the buffer controller advances its own write address on every strobe, the write count per capture is exact: a truncated frame is zero-padded so the buffer address always returns to 0 after a capture.

## Interface
- SRC_W, 640: active pixels per source line
- SRC_H, 480: active lines per source frame
- X0, 128: first source column inside the window
- Y0, 48: first source line inside the window
- STEP, 3: subsample step in x and y
- DST_W, 128: output pixels per line
- DST_H, 128: output lines (DST_W*DST_H = 16384)

Ports:
- i_clk  in  1  system clock, all logic on posedge
- i_rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- i_start  in  1  single-cycle capture request
- i_fval  in  1  source frame valid, high for the whole frame
- i_dval  in  1  source pixel valid; pixels arrive in raster order, SRC_W per line
- i_r, i_g, i_b  in  12 each  source pixel channels
- o_wen  out  1  write strobe to the image buffer, one word per cycle high
- o_data  out  24  {r[11:4], g[11:4], b[11:4]}
- o_busy  out  1  high from accepted i_start until capture complete
- o_done  out  1  one-cycle pulse when the 16384th write is issued

## Operation
- State IDLE (reset):
  - i_start=1 → WAIT_SOF.
  - i_start in any other state is ignored.
- State WAIT_SOF:
  - Waits for a rising edge of i_fval, detected with a registered copy of i_fval.
  - If i_fval is already high when entered, waits for the next frame's rising edge.
  - On the edge, clears sx, sy, ox, oy and wcnt → CAPTURE.
- State CAPTURE, counters:
  - Each i_dval=1 cycle advances the source column sx (0..SRC_W-1).
  - At sx=SRC_W-1, sx wraps to 0 and the source line sy increments.
- State CAPTURE, pixel selection:
  - A pixel is kept when sx in [X0, X0+STEP*DST_W-1], sy in [Y0, Y0+STEP*DST_H-1], and the x phase counter and y phase counter are both 0.
  - Phase counters run 0..STEP-1; no divider or modulo operator.
  - Each kept pixel produces one write and increments wcnt (15 bits).
- State CAPTURE, exits:
  - wcnt reaching 16384 → DONE. Further source pixels in the frame are ignored.
  - i_fval falling with wcnt<16384 → FILL.
- State FILL: one write of data 24'h0 per cycle until wcnt=16384 → DONE.
- State DONE: lasts one cycle; o_done=1 → IDLE.
- o_busy=1 in WAIT_SOF, CAPTURE, FILL, DONE.
- Reset mid-operation:
  - Immediately returns to IDLE with all outputs 0.
  - The image buffer shares the same reset, so address alignment is preserved.

## Timing
- Reset values: o_wen=0, o_data=0, o_busy=0, o_done=0.
- All outputs are registered.
- Write latency:
  - A kept pixel sampled at edge N appears with o_wen=1 after edge N (1 cycle latency).
  - o_data is valid in the same cycle as o_wen.
  - o_data holds its last value when o_wen=0.
- No backpressure: the buffer accepts a write every cycle, so consecutive o_wen cycles are legal.
- o_done is asserted in the cycle after the final o_wen. o_busy falls together with o_done.
- i_start is sampled in IDLE; a new capture can be requested the cycle after o_done.
- i_fval falling and the final kept pixel in the same cycle: the pixel is written, wcnt reaches 16384, go DONE, no FILL.

## Structure
- Shared package `img_pkg`:
  - localparams IMG_W=128, IMG_H=128, IMG_WORDS=16384, PIX_W=24.
  - typedef `pix24_t` (packed r,g,b bytes).
  - State enum `cap_state_e`: IDLE, WAIT_SOF, CAPTURE, FILL, DONE.
- One sub-module, `raster_counter`:
  - Holds sx/sy and the phase counters.
  - Output `keep` plus end-of-line / end-of-frame flags.
- Top: FSM, wcnt, output registers.

## Test plan
- Start, then one full 640×480 frame with i_dval continuous:
  - Exactly 16384 o_wen.
  - First write is source pixel (128,48).
  - Second write is (131,48).
  - 129th write is (128,51).
  - o_done one cycle after the last write.
- Pixel r=12'hABC, g=12'h123, b=12'hFFF at (128,48) → o_data=24'hAB12FF on the first write.
- Start asserted while i_fval is high mid-frame:
  - No writes until the next i_fval rise.
  - Then a normal 16384-write capture.
- Frame aborted (i_fval low) after 200 source lines:
  - Kept writes are followed by back-to-back zero writes.
  - Total is 16384, then o_done.
- i_dval with idle gaps, 1 valid every 3 cycles: the same pixel sequence as the continuous case.
- i_rst_n low during CAPTURE after 5000 writes:
  - All outputs 0 asynchronously, state IDLE.
  - A new start gives a full 16384-write capture from pixel (128,48).

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and default geometry for the 128x128 image buffer path.
package img_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int IMG_WORDS = IMG_W * IMG_H;
  localparam int PIX_W     = 24;

  localparam int SRC_W_DEF = 640;
  localparam int SRC_H_DEF = 480;
  localparam int X0_DEF    = 128;
  localparam int Y0_DEF    = 48;
  localparam int STEP_DEF  = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix24_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    FILL,
    DONE
  } cap_state_e;

endpackage

// File: rtl/raster_counter.sv
// Source raster position tracking and window/subsample selection.
module raster_counter
  import img_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF,
  parameter int X0    = X0_DEF,
  parameter int Y0    = Y0_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int DST_W = IMG_W,
  parameter int DST_H = IMG_H
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic adv_i,
  output logic keep_o,
  output logic eof_o
);

  localparam int XW = $clog2(SRC_W);
  localparam int YW = $clog2(SRC_H);
  localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;

  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;
  logic [PW-1:0] px_q, px_d;
  logic [PW-1:0] py_q, py_d;
  logic          in_x, in_y, eol;

  assign in_x = (sx_q >= XW'(X0)) &&
                (sx_q <= XW'(X0 + STEP*DST_W - 1));
  assign in_y = (sy_q >= YW'(Y0)) &&
                (sy_q <= YW'(Y0 + STEP*DST_H - 1));
  assign eol  = adv_i && (sx_q == XW'(SRC_W - 1));

  assign eof_o  = eol && (sy_q == YW'(SRC_H - 1));
  assign keep_o = adv_i && in_x && in_y &&
                  (px_q == '0) && (py_q == '0);

  // Phase counters only run inside the window, so they read 0 at X0/Y0.
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    px_d = px_q;
    py_d = py_q;
    if (clr_i) begin
      sx_d = '0;
      sy_d = '0;
      px_d = '0;
      py_d = '0;
    end else if (adv_i) begin
      if (eol) begin
        sx_d = '0;
        px_d = '0;
        sy_d = eof_o ? '0 : sy_q + 1'b1;
        if (in_y)
          py_d = (py_q == PW'(STEP - 1)) ? '0 : py_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
        if (in_x)
          px_d = (px_q == PW'(STEP - 1)) ? '0 : px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sx_q <= '0;
      sy_q <= '0;
      px_q <= '0;
      py_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      px_q <= px_d;
      py_q <= py_d;
    end
  end

endmodule

// File: rtl/frame_decimator.sv
// Captures a subsampled window of one camera frame into the image buffer,
// always issuing exactly DST_W*DST_H writes (zero-padded on short frames).
module frame_decimator
  import img_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF,
  parameter int X0    = X0_DEF,
  parameter int Y0    = Y0_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int DST_W = IMG_W,
  parameter int DST_H = IMG_H
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_fval,
  input  logic             i_dval,
  input  logic [11:0]      i_r,
  input  logic [11:0]      i_g,
  input  logic [11:0]      i_b,
  output logic             o_wen,
  output logic [PIX_W-1:0] o_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int WORDS = DST_W * DST_H;
  localparam int WCW   = $clog2(WORDS + 1);

  cap_state_e     state_q, state_d;
  logic           fval_q;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           wen_q, wen_d;
  pix24_t         data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic clr, adv, keep, eof;
  logic rise, fall, last;
  logic unused_lsb;

  assign unused_lsb = ^{i_r[3:0], i_g[3:0], i_b[3:0]};

  assign adv  = (state_q == CAPTURE) && i_dval;
  assign rise = i_fval && !fval_q;
  assign fall = fval_q && !i_fval;
  assign last = (wcnt_q == WCW'(WORDS - 1));

  raster_counter #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .X0    (X0),
    .Y0    (Y0),
    .STEP  (STEP),
    .DST_W (DST_W),
    .DST_H (DST_H)
  ) u_rc (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (clr),
    .adv_i  (adv),
    .keep_o (keep),
    .eof_o  (eof)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wen_d   = 1'b0;
    data_d  = data_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (rise) begin
          clr     = 1'b1;
          wcnt_d  = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // A final pixel coinciding with frame end completes without FILL.
        if (keep) begin
          wen_d  = 1'b1;
          data_d = '{r: i_r[11:4], g: i_g[11:4], b: i_b[11:4]};
          wcnt_d = wcnt_q + 1'b1;
        end
        if (keep && last)
          state_d = DONE;
        else if (fall || eof)
          state_d = FILL;
      end
      FILL: begin
        wen_d  = 1'b1;
        data_d = '0;
        wcnt_d = wcnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_d = (state_q == DONE);
  assign busy_d = (state_d != IDLE) || (state_q == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      fval_q  <= 1'b0;
      wcnt_q  <= '0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= i_fval;
      wcnt_q  <= wcnt_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_wen  = wen_q;
  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_frame_decimator.sv
// Randomised scenario bench for frame_decimator on a scaled-down raster.
module tb_frame_decimator;

  localparam int SW    = 40;
  localparam int SH    = 30;
  localparam int X0    = 5;
  localparam int Y0    = 3;
  localparam int ST    = 3;
  localparam int DW    = 8;
  localparam int DH    = 6;
  localparam int WORDS = DW * DH;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_fval = 1'b0;
  logic        i_dval = 1'b0;
  logic [11:0] i_r = '0, i_g = '0, i_b = '0;
  logic        o_wen;
  logic [23:0] o_data;
  logic        o_busy;
  logic        o_done;

  frame_decimator #(
    .SRC_W (SW), .SRC_H (SH), .X0 (X0), .Y0 (Y0),
    .STEP (ST), .DST_W (DW), .DST_H (DH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_fval  (i_fval),
    .i_dval  (i_dval),
    .i_r     (i_r),
    .i_g     (i_g),
    .i_b     (i_b),
    .o_wen   (o_wen),
    .o_data  (o_data),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  logic busy_at_done = 1'b0;
  logic busy_after = 1'b1;
  logic prev_done = 1'b0;
  logic [23:0] got[$];
  int          wcyc[$];
  logic [23:0] exp_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_wen) begin
        got.push_back(o_data);
        wcyc.push_back(cyc);
      end
      if (o_done) begin
        done_n <= done_n + 1;
        done_cyc <= cyc;
        busy_at_done <= o_busy;
      end
      if (prev_done) busy_after <= o_busy;
      prev_done <= o_done;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_q();
    got.delete();
    wcyc.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  function automatic bit model_keep(int x, int y);
    return x >= X0 && x < X0 + ST*DW && (x - X0) % ST == 0 &&
           y >= Y0 && y < Y0 + ST*DH && (y - Y0) % ST == 0;
  endfunction

  function automatic logic [23:0] got_at(int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  function automatic int data_errs();
    int e = 0;
    for (int i = 0; i < WORDS; i++)
      if (i >= got.size() || i >= exp_q.size() || got[i] !== exp_q[i])
        e++;
    return e;
  endfunction

  function automatic int last_wcyc();
    if (wcyc.size() == 0) return -100;
    return wcyc[wcyc.size()-1];
  endfunction

  task automatic drive_frame(input int gap, input int lines,
                             input bit fix, input bit cut,
                             input int rst_after, output bit did_rst);
    logic [11:0] r, g, b;
    did_rst = 1'b0;
    i_fval = 1'b1;
    i_dval = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < SW; x++) begin
        i_dval = 1'b0;
        repeat (gap) tick();
        r = 12'($urandom);
        g = 12'($urandom);
        b = 12'($urandom);
        if (fix && x == X0 && y == Y0) begin
          r = 12'hABC; g = 12'h123; b = 12'hFFF;
        end
        i_dval = 1'b1;
        i_r = r; i_g = g; i_b = b;
        if (model_keep(x, y) && exp_q.size() < WORDS) begin
          exp_q.push_back({r[11:4], g[11:4], b[11:4]});
          if (cut && exp_q.size() == WORDS) i_fval = 1'b0;
        end
        tick();
        if (cut && exp_q.size() == WORDS) begin
          i_dval = 1'b0;
          tick();
          return;
        end
        if (rst_after > 0 && got.size() >= rst_after) begin
          #2;
          i_rst_n = 1'b0;
          i_dval = 1'b0;
          i_fval = 1'b0;
          did_rst = 1'b1;
          return;
        end
      end
      i_dval = 1'b0;
      repeat (2) tick();
    end
    i_fval = 1'b0;
    i_dval = 1'b0;
    tick();
    while (exp_q.size() < WORDS) exp_q.push_back(24'h0);
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      #1;
      if (done_n > n0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (o_wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen got %b want 0", o_wen); end
    n_cmp++; if (o_data !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", o_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_done); end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    bit dr, ok;
    int n0, e;
    clear_q();
    n0 = done_n;
    pulse_start();
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL full_busy got %b want 1", o_busy); end
    drive_frame(0, SH, 1'b1, 1'b0, 0, dr);
    wait_done(n0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_done_seen got 0 want 1"); end
    n_cmp++; if (got.size() != WORDS) begin n_bad++; $display("FAIL full_count got %0d want %0d", got.size(), WORDS); end
    e = data_errs();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL full_data got %0d bad words want 0", e); end
    n_cmp++; if (got_at(0) !== 24'hAB12FF) begin n_bad++; $display("FAIL full_first got %h want ab12ff", got_at(0)); end
    n_cmp++; if (got_at(1) !== exp_q[1]) begin n_bad++; $display("FAIL full_second got %h want %h", got_at(1), exp_q[1]); end
    n_cmp++; if (got_at(DW) !== exp_q[DW]) begin n_bad++; $display("FAIL full_row2 got %h want %h", got_at(DW), exp_q[DW]); end
    n_cmp++; if (done_cyc != last_wcyc() + 1) begin n_bad++; $display("FAIL full_done_lat got %0d want %0d", done_cyc, last_wcyc() + 1); end
    n_cmp++; if (busy_at_done !== 1'b1) begin n_bad++; $display("FAIL full_busy_done got %b want 1", busy_at_done); end
    n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL full_busy_after got %b want 0", busy_after); end
  endtask

  task automatic test_midframe_start();
    bit dr, ok;
    int n0, e;
    clear_q();
    n0 = done_n;
    i_fval = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 120; i++) begin
      i_dval = 1'b1;
      i_r = 12'($urandom); i_g = 12'($urandom); i_b = 12'($urandom);
      if (i == 60) i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    i_dval = 1'b0;
    i_fval = 1'b0;
    repeat (3) tick();
    n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL mid_early_writes got %0d want 0", got.size()); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", o_busy); end
    drive_frame(0, SH, 1'b0, 1'b0, 0, dr);
    wait_done(n0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_done_seen got 0 want 1"); end
    n_cmp++; if (got.size() != WORDS) begin n_bad++; $display("FAIL mid_count got %0d want %0d", got.size(), WORDS); end
    e = data_errs();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL mid_data got %0d bad words want 0", e); end
  endtask

  task automatic test_abort();
    bit dr, ok;
    int n0, e, kept, span;
    kept = 0;
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < SW; x++)
        if (model_keep(x, y)) kept++;
    clear_q();
    n0 = done_n;
    pulse_start();
    drive_frame(0, 10, 1'b0, 1'b0, 0, dr);
    wait_done(n0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_done_seen got 0 want 1"); end
    n_cmp++; if (got.size() != WORDS) begin n_bad++; $display("FAIL abort_count got %0d want %0d", got.size(), WORDS); end
    e = data_errs();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL abort_data got %0d bad words want 0", e); end
    span = (wcyc.size() == WORDS) ? wcyc[WORDS-1] - wcyc[kept] : -1;
    n_cmp++; if (span != WORDS - 1 - kept) begin n_bad++; $display("FAIL abort_fill_span got %0d want %0d", span, WORDS - 1 - kept); end
    n_cmp++; if (done_cyc != last_wcyc() + 1) begin n_bad++; $display("FAIL abort_done_lat got %0d want %0d", done_cyc, last_wcyc() + 1); end
  endtask

  task automatic test_cut_last();
    bit dr, ok;
    int n0, e;
    clear_q();
    n0 = done_n;
    pulse_start();
    drive_frame(0, SH, 1'b0, 1'b1, 0, dr);
    wait_done(n0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cut_done_seen got 0 want 1"); end
    n_cmp++; if (got.size() != WORDS) begin n_bad++; $display("FAIL cut_count got %0d want %0d", got.size(), WORDS); end
    e = data_errs();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL cut_data got %0d bad words want 0", e); end
    n_cmp++; if (done_cyc != last_wcyc() + 1) begin n_bad++; $display("FAIL cut_done_lat got %0d want %0d", done_cyc, last_wcyc() + 1); end
  endtask

  task automatic test_gaps_back_to_back();
    bit dr, ok;
    int n0, e;
    clear_q();
    n0 = done_n;
    pulse_start();
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL gap_restart_busy got %b want 1", o_busy); end
    drive_frame(2, SH, 1'b1, 1'b0, 0, dr);
    wait_done(n0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gap_done_seen got 0 want 1"); end
    n_cmp++; if (got.size() != WORDS) begin n_bad++; $display("FAIL gap_count got %0d want %0d", got.size(), WORDS); end
    e = data_errs();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL gap_data got %0d bad words want 0", e); end
    n_cmp++; if (got_at(0) !== 24'hAB12FF) begin n_bad++; $display("FAIL gap_first got %h want ab12ff", got_at(0)); end
  endtask

  task automatic test_reset_mid();
    bit dr, ok;
    int n0, e;
    clear_q();
    pulse_start();
    drive_frame(0, SH, 1'b0, 1'b0, 20, dr);
    #1;
    n_cmp++; if (dr !== 1'b1) begin n_bad++; $display("FAIL rstmid_reached got %b want 1", dr); end
    n_cmp++; if ({o_wen, o_busy, o_done} !== 3'b000) begin n_bad++; $display("FAIL rstmid_ctrl got %b want 000", {o_wen, o_busy, o_done}); end
    n_cmp++; if (o_data !== 24'h0) begin n_bad++; $display("FAIL rstmid_data got %h want 0", o_data); end
    tick();
    i_rst_n = 1'b1;
    tick();
    clear_q();
    n0 = done_n;
    pulse_start();
    drive_frame(0, SH, 1'b1, 1'b0, 0, dr);
    wait_done(n0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_done_seen got 0 want 1"); end
    n_cmp++; if (got.size() != WORDS) begin n_bad++; $display("FAIL rstmid_count got %0d want %0d", got.size(), WORDS); end
    e = data_errs();
    n_cmp++; if (e != 0) begin n_bad++; $display("FAIL rstmid_data_seq got %0d bad words want 0", e); end
    n_cmp++; if (got_at(0) !== 24'hAB12FF) begin n_bad++; $display("FAIL rstmid_first got %h want ab12ff", got_at(0)); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_midframe_start();
    test_abort();
    test_gaps_back_to_back();
    test_cut_last();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
